// File: rtl/cp0_if.sv
// CP0 strobe/data bundle between the main control FSM and the CP0 unit.
// master: control FSM side, drives the CP0 strobes and write data.
// slave : CP0 side, returns the read mux, Status, EPC, vector and INT.
interface cp0_if;
    logic        mtc0;
    logic [4:0]  rd_addr;
    logic [31:0] wdata;
    logic [31:0] pc_in;
    logic        wcau;
    logic        wepc;
    logic        wsta;
    logic        exc;
    logic        eret;
    logic        cp0_selcause;
    logic        inta;
    logic [31:0] rdata;
    logic [31:0] cp0_status;
    logic [31:0] epc_out;
    logic [31:0] vector_out;
    logic        INT;

    modport master (
        output mtc0, rd_addr, wdata, pc_in, wcau, wepc, wsta, exc, eret,
               cp0_selcause, inta,
        input  rdata, cp0_status, epc_out, vector_out, INT
    );

    modport slave (
        input  mtc0, rd_addr, wdata, pc_in, wcau, wepc, wsta, exc, eret,
               cp0_selcause, inta,
        output rdata, cp0_status, epc_out, vector_out, INT
    );
endinterface

// File: rtl/cp0_unit.sv
// System coprocessor 0: Status (12), Cause (13) and EPC (14), plus the
// external interrupt synchroniser / pending latch and the INT request.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   irq      - asynchronous level interrupt lines, a rising edge latches a request
//   bus      - cp0_if.slave: CP0 strobes from the control FSM, read/status outputs
module cp0_unit #(
    parameter int          N_IRQ        = 4,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_IRQ-1:0] irq,
    cp0_if.slave             bus
);

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    logic             ie;
    logic             exl;
    logic [N_IRQ-1:0] im;
    logic [4:0]       exc_code;
    logic [31:0]      epc;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] sync1, sync2, sync3;
    logic             int_q;

    logic             wr_status, wr_cause, wr_epc;
    logic [N_IRQ-1:0] rise, cand, ack_mask, w1c_mask, pending_nxt;
    logic             found;
    logic [31:0]      status_w, cause_w;

    assign wr_status = bus.mtc0 && (bus.rd_addr == REG_STATUS);
    assign wr_cause  = bus.mtc0 && (bus.rd_addr == REG_CAUSE);
    assign wr_epc    = bus.mtc0 && (bus.rd_addr == REG_EPC);

    assign rise = sync2 & ~sync3;
    assign cand = pending & im;

    // inta acknowledges only the highest-priority (lowest index) enabled line
    always_comb begin
        ack_mask = '0;
        found    = 1'b0;
        if (bus.inta) begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (!found && cand[i]) begin
                    ack_mask[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    assign w1c_mask = wr_cause ? bus.wdata[8 +: N_IRQ] : '0;

    // OR-ing rise in last guarantees a new request survives a same-cycle clear
    assign pending_nxt = (pending & ~(ack_mask | w1c_mask)) | rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            sync3   <= '0;
            pending <= '0;
            int_q   <= 1'b0;
        end else begin
            sync1   <= irq;
            sync2   <= sync1;
            sync3   <= sync2;
            pending <= pending_nxt;
            int_q   <= (|cand) & ie & ~exl;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie       <= 1'b0;
            exl      <= 1'b0;
            im       <= '0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            if (wr_status) begin
                ie <= bus.wdata[0];
                im <= bus.wdata[8 +: N_IRQ];
            end
            // hardware EXL update takes precedence over a software write
            if (bus.wsta) begin
                if (bus.exc) begin
                    exl <= 1'b1;
                end else if (bus.eret) begin
                    exl <= 1'b0;
                end
            end else if (wr_status) begin
                exl <= bus.wdata[1];
            end
            if (bus.wcau) begin
                exc_code <= bus.cp0_selcause ? 5'd0 : 5'd8;
            end
            if (bus.wepc) begin
                epc <= bus.pc_in;
            end else if (wr_epc) begin
                epc <= bus.wdata;
            end
        end
    end

    always_comb begin
        status_w              = '0;
        status_w[0]           = ie;
        status_w[1]           = exl;
        status_w[8 +: N_IRQ]  = im;
        cause_w               = '0;
        cause_w[6:2]          = exc_code;
        cause_w[8 +: N_IRQ]   = pending;
    end

    always_comb begin
        case (bus.rd_addr)
            REG_STATUS: bus.rdata = status_w;
            REG_CAUSE:  bus.rdata = cause_w;
            REG_EPC:    bus.rdata = epc;
            default:    bus.rdata = 32'd0;
        endcase
    end

    assign bus.cp0_status = status_w;
    assign bus.epc_out    = epc;
    assign bus.vector_out = HANDLER_ADDR;
    assign bus.INT        = int_q;

endmodule
